seq_shifter_left: RTL and testbench
===================================

# seq_shifter_left

Multi-cycle left shifter for the processor ALU, the left-going counterpart of the right-shift unit. It loads an 8-bit operand and an 8-bit shift magnitude on a START pulse, then performs a logical left shift one bit position per clock. It signals completion with a one-cycle DONE pulse and holds the result until the next operation. It sits beside the ALU and is sequenced by the control unit via START/BUSY/DONE.

## Interface
- WIDTH, 8, data width; fixed at 8 for this processor (shift magnitude port also 8 bits)
- CLK  input  1  system clock, rising-edge active
- RESET  input  1  asynchronous, active-high reset
- START  input  1  request; sampled only in IDLE
- DATA_IN  input  8  operand, sampled on accepted START edge
- LSHIFT  input  8  shift magnitude, unsigned, sampled on accepted START edge
- ROTATE  input  1  present only with SEQ_SHIFT_ROTATE_EN; sampled on accepted START edge
- RESULT  output  8  shift register contents; valid while DONE=1, held until next accepted START
- BUSY  output  1  high while in SHIFT
- DONE  output  1  one-cycle completion pulse

## Operation
- States: IDLE, SHIFT, FINISH; 8-bit REG, 4-bit CNT.
- IDLE, START=1 at edge: accept, REG<=DATA_IN, CNT<=LSHIFT[2:0]. If LSHIFT>=8 (any of bits 7..3 set): REG<=8'h00, CNT<=0. Next state SHIFT if CNT load !=0, else FINISH.
- SHIFT: each edge REG<={REG[6:0],1'b0}, CNT<=CNT-1; when CNT==1 at the edge -> FINISH.
- FINISH: DONE=1 for exactly one cycle; next edge -> IDLE unconditionally.
- START in SHIFT or FINISH: ignored, no queuing; must be reasserted in IDLE.
- Inputs DATA_IN/LSHIFT changing after acceptance: no effect.
- RESULT = REG at all times; REG is not modified in IDLE or FINISH.

## Timing
- Reset (asynchronous, any state, including mid-shift): state IDLE, REG=8'h00, CNT=0, RESULT=8'h00, BUSY=0, DONE=0; in-flight operation discarded, no DONE.
- Accepting edge = edge 0. Effective magnitude N = LSHIFT if <8, else 0 (with zeroed REG).
- DONE high in the cycle following edge N (N=0: cycle after edge 0; N=7: cycle after edge 7).
- BUSY high in the cycles following edges 0..N-1 (never high for N=0).
- Earliest next accepted START: edge N+2.
- BUSY and DONE are never simultaneously high.

## Configuration
- SEQ_SHIFT_ROTATE_EN defined: ROTATE port exists. ROTATE=1 at accept: SHIFT step is REG<={REG[6:0],REG[7]}; magnitude taken as LSHIFT[2:0] only (mod 8); no zeroing for LSHIFT>=8. ROTATE=0: logical behaviour as above.
- Not defined: ROTATE port absent, logical left shift only.

## Structure
- Shared package/header: WIDTH constant, state encodings (IDLE=2'b00, SHIFT=2'b01, FINISH=2'b10), overflow threshold 8.
- One sub-module: shift_step_left, combinational one-position step (logical or rotate select), instantiated once in the REG next-state path.
- Top holds FSM, CNT, REG, load/zero mux.

## Test plan
- DATA_IN=8'hB5, LSHIFT=3, START pulse -> DONE after edge 3, RESULT=8'hA8, BUSY high exactly 3 cycles.
- DATA_IN=8'h81, LSHIFT=0 -> DONE in cycle after edge 0, RESULT=8'h81, BUSY never high.
- DATA_IN=8'hFF, LSHIFT=8'h09 -> DONE after edge 0, RESULT=8'h00; repeat with LSHIFT=8'h80 -> same.
- LSHIFT=7, DATA_IN=8'h03; RESET pulse after edge 4 -> outputs 0 immediately, no DONE; subsequent START DATA_IN=8'h01, LSHIFT=1 -> RESULT=8'h02.
- Operation LSHIFT=5 running; START with new data held high through SHIFT/FINISH -> ignored until IDLE, then accepted at edge 7 (edge N+2).
- SEQ_SHIFT_ROTATE_EN, ROTATE=1, DATA_IN=8'h96, LSHIFT=8'h0B -> effective 3, RESULT=8'hB4, DONE after edge 3.

Source files
------------

// File: rtl/seq_shifter_left_pkg.sv
// Shared definitions for the sequential left shifter: data width, FSM encoding
// and the magnitude at which a logical shift clears the operand.
package seq_shifter_left_pkg;

  localparam int WIDTH = 8;

  localparam logic [WIDTH-1:0] SHIFT_LIMIT = 8'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    FINISH = 2'b10
  } state_t;

endpackage

// File: rtl/seq_shifter_left_step.sv
// One-position left step: the vacated LSB is filled with zero, or with the
// outgoing MSB when rotating.
module shift_step_left
  import seq_shifter_left_pkg::*;
(
  input  logic [WIDTH-1:0] din,
  input  logic             rotate,
  output logic [WIDTH-1:0] dout
);

  assign dout = rotate ? {din[WIDTH-2:0], din[WIDTH-1]}
                       : {din[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/seq_shifter_left.sv
// Multi-cycle left shifter, one bit position per clock, sequenced by START/BUSY/DONE.
// Optional rotate mode is enabled by defining SEQ_SHIFT_ROTATE_EN.
module seq_shifter_left
  import seq_shifter_left_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] lshift,
`ifdef SEQ_SHIFT_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d, step;
  logic [3:0]       cnt_q, cnt_d;
  logic             rot_q, rot_d;
  logic             rot_in;
  logic             over;

`ifdef SEQ_SHIFT_ROTATE_EN
  assign rot_in = rotate;
`else
  assign rot_in = 1'b0;
`endif

  assign over = (lshift >= SHIFT_LIMIT);

  shift_step_left u_step (
    .din    (reg_q),
    .rotate (rot_q),
    .dout   (step)
  );

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    rot_d   = rot_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rot_d = rot_in;
          reg_d = data_in;
          cnt_d = {1'b0, lshift[2:0]};
          // Logical shifts of 8 or more clear the operand; rotates wrap mod 8.
          if (over && !rot_in) begin
            reg_d = '0;
            cnt_d = '0;
          end
          state_d = (cnt_d != 4'd0) ? SHIFT : FINISH;
        end
      end
      SHIFT: begin
        busy  = 1'b1;
        reg_d = step;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      reg_q   <= '0;
      cnt_q   <= '0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      rot_q   <= rot_d;
    end
  end

  assign result = reg_q;

endmodule

// File: tb/tb_seq_shifter_left.sv
// Randomised self-checking bench for seq_shifter_left against a behavioural
// model of the shift result and DONE/BUSY timing.
module tb_seq_shifter_left;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic [7:0] lshift;
`ifdef SEQ_SHIFT_ROTATE_EN
  logic       rotate;
`endif
  logic [7:0] result;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] d;
    logic [7:0] l;
    logic       r;
  } op_t;

  op_t ops[$];

  always #5 clk = ~clk;

  seq_shifter_left dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .lshift  (lshift),
`ifdef SEQ_SHIFT_ROTATE_EN
    .rotate  (rotate),
`endif
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  function automatic int eff_n(logic [7:0] l, logic r);
    if (r) return int'(l) % 8;
    return (l >= 8) ? 0 : int'(l);
  endfunction

  function automatic logic [7:0] model(logic [7:0] d, logic [7:0] l, logic r);
    int n;
    int v;
    n = eff_n(l, r);
    v = int'(d);
    if (r)            v = (v << n) | (v >> (8 - n));
    else if (l >= 8)  v = 0;
    else              v = v << n;
    return v[7:0];
  endfunction

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; data_in = 8'h00; lshift = 8'h00;
`ifdef SEQ_SHIFT_ROTATE_EN
    rotate = 1'b0;
`endif
    repeat (2) @(negedge clk);
    tests++; if (result !== 8'h00) begin fails++; $display("FAIL reset_result got=%h exp=00", result); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_operations;
    op_t        o;
    int         n;
    int         busy_cnt;
    logic [7:0] exp;
    ops.delete();
    ops.push_back('{8'hB5, 8'd3,  1'b0});
    ops.push_back('{8'h81, 8'd0,  1'b0});
    ops.push_back('{8'hFF, 8'h09, 1'b0});
    ops.push_back('{8'hFF, 8'h80, 1'b0});
    ops.push_back('{8'h01, 8'd7,  1'b0});
`ifdef SEQ_SHIFT_ROTATE_EN
    ops.push_back('{8'h96, 8'h0B, 1'b1});
    ops.push_back('{8'hC3, 8'h88, 1'b1});
`endif
    for (int i = 0; i < 40; i++) begin
      o.d = 8'($urandom);
      o.l = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
`ifdef SEQ_SHIFT_ROTATE_EN
      o.r = 1'($urandom_range(0, 1));
`else
      o.r = 1'b0;
`endif
      ops.push_back(o);
    end
    foreach (ops[i]) begin
      o = ops[i];
      n = eff_n(o.l, o.r);
      exp = model(o.d, o.l, o.r);
      busy_cnt = 0;
      @(negedge clk);
      start = 1'b1; data_in = o.d; lshift = o.l;
`ifdef SEQ_SHIFT_ROTATE_EN
      rotate = o.r;
`endif
      for (int k = 0; k <= n; k++) begin
        @(negedge clk);
        // START and operands wiggle while the operation is in flight.
        start = 1'($urandom_range(0, 1)); data_in = 8'($urandom); lshift = 8'($urandom);
`ifdef SEQ_SHIFT_ROTATE_EN
        rotate = 1'($urandom_range(0, 1));
`endif
        tests++;
        if (busy !== (k < n)) begin
          fails++; $display("FAIL op%0d_busy edge=%0d got=%b exp=%b", i, k, busy, (k < n));
        end
        tests++;
        if (done !== (k == n)) begin
          fails++; $display("FAIL op%0d_done edge=%0d got=%b exp=%b", i, k, done, (k == n));
        end
        if (busy === 1'b1) busy_cnt++;
      end
      tests++;
      if (result !== exp) begin
        fails++; $display("FAIL op%0d_result d=%h l=%h r=%b got=%h exp=%h", i, o.d, o.l, o.r, result, exp);
      end
      tests++;
      if (busy_cnt != n) begin
        fails++; $display("FAIL op%0d_busy_cycles got=%0d exp=%0d", i, busy_cnt, n);
      end
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
        fails++; $display("FAIL op%0d_hold done=%b busy=%b result=%h exp=0/0/%h", i, done, busy, result, exp);
      end
    end
  endtask

  task automatic test_reset_midshift;
    @(negedge clk);
    start = 1'b1; data_in = 8'h03; lshift = 8'd7;
`ifdef SEQ_SHIFT_ROTATE_EN
    rotate = 1'b0;
`endif
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (result !== 8'h30 || busy !== 1'b1) begin
      fails++; $display("FAIL midshift_pre result=%h busy=%b exp=30/1", result, busy);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (result !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL async_reset result=%h busy=%b done=%b exp=00/0/0", result, busy, done);
    end
    #1 reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL post_reset_idle cyc=%0d done=%b busy=%b exp=0/0", k, done, busy);
      end
    end
    start = 1'b1; data_in = 8'h01; lshift = 8'd1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL post_reset_busy got=%b exp=1", busy); end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || result !== 8'h02) begin
      fails++; $display("FAIL post_reset_op done=%b result=%h exp=1/02", done, result);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] a, b;
    logic       exp_busy, exp_done;
    a = 8'($urandom); b = 8'($urandom);
    @(negedge clk);
    start = 1'b1; data_in = a; lshift = 8'd5;
`ifdef SEQ_SHIFT_ROTATE_EN
    rotate = 1'b0;
`endif
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 0) begin data_in = b; lshift = 8'd2; end
      exp_busy = (k < 5) || (k == 7) || (k == 8);
      exp_done = (k == 5) || (k == 9);
      tests++;
      if (busy !== exp_busy) begin
        fails++; $display("FAIL b2b_busy edge=%0d got=%b exp=%b", k, busy, exp_busy);
      end
      tests++;
      if (done !== exp_done) begin
        fails++; $display("FAIL b2b_done edge=%0d got=%b exp=%b", k, done, exp_done);
      end
      if (k == 5 || k == 6) begin
        tests++;
        if (result !== model(a, 8'd5, 1'b0)) begin
          fails++; $display("FAIL b2b_first edge=%0d got=%h exp=%h", k, result, model(a, 8'd5, 1'b0));
        end
      end
      if (k == 7) start = 1'b0;
    end
    tests++;
    if (result !== model(b, 8'd2, 1'b0)) begin
      fails++; $display("FAIL b2b_second got=%h exp=%h", result, model(b, 8'd2, 1'b0));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_operations();
    test_reset_midshift();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
